// File: rtl/top_module_add4.sv
// Carry-lookahead adder with an in_valid-qualified result register.
// The combinational sum/carry path is stateless; the registered path adds overflow and zero flags.
module top_module_add4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_gen;   // carry into bit i+1 assuming cin = 0
  logic [WIDTH-1:0] w_prop;  // AND of p[i:0]
  logic [WIDTH:0]   w_c;
  logic             w_run;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_ovf_q;
  logic             r_zero_q;
  logic             r_out_valid;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flat sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_gen  = '0;
    w_prop = '0;
    w_c    = '0;
    w_run  = 1'b1;
    w_c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_gen[i] = w_gen[i] | (w_g[j] & w_run);
        w_run    = w_run & w_p[j];
      end
      w_prop[i]  = w_run;
      w_c[i+1]   = w_gen[i] | (w_prop[i] & cin);
    end
  end

  assign sum   = w_p ^ w_c[WIDTH-1:0];
  assign cout  = w_c[WIDTH];
  assign grp_p = w_prop[MSB];
  assign grp_g = w_gen[MSB];
  assign w_ovf = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= '0;
      r_cout_q    <= 1'b0;
      r_ovf_q     <= 1'b0;
      r_zero_q    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q  <= sum;
        r_cout_q <= cout;
        r_ovf_q  <= w_ovf;
        r_zero_q <= (sum == '0);
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign ovf_q     = r_ovf_q;
  assign zero_q    = r_zero_q;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_top_module_add4.sv
// Self-checking bench for top_module_add4: exhaustive combinational sweep, directed corner
// cases, reset behaviour and a randomized stream scored against an arithmetic model.
module tb_top_module_add4;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         grp_p;
  logic         grp_g;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;
  logic         zero_q;
  logic         out_valid;

  bit clk_en = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  // Reference register state.
  logic [W-1:0] m_sum_q   = '0;
  logic         m_cout_q  = 1'b0;
  logic         m_ovf_q   = 1'b0;
  logic         m_zero_q  = 1'b0;
  logic         m_valid   = 1'b0;

  top_module_add4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .grp_p(grp_p), .grp_g(grp_g),
    .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q), .zero_q(zero_q), .out_valid(out_valid)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {grp_p, grp_g, cout, sum} from plain integer arithmetic.
  function automatic logic [31:0] ref_comb(input int ia, input int ib, input int ic);
    int total;
    total = ia + ib + ic;
    return {25'd0, ((ia ^ ib) == MOD - 1), ((ia + ib) >= MOD), (total >= MOD), W'(total % MOD)};
  endfunction

  // Signed overflow: true result outside the representable two's-complement range.
  function automatic logic ref_ovf(input int ia, input int ib, input int ic);
    int sa, sb, st;
    sa = (ia >= MOD / 2) ? ia - MOD : ia;
    sb = (ib >= MOD / 2) ? ib - MOD : ib;
    st = sa + sb + ic;
    return (st > MOD / 2 - 1) || (st < -(MOD / 2));
  endfunction

  task automatic check_comb(input string tag);
    check(tag, {25'd0, grp_p, grp_g, cout, sum}, ref_comb(int'(a), int'(b), int'(cin)));
  endtask

  task automatic check_regs(input string tag);
    check(tag, {27'd0, out_valid, zero_q, ovf_q, cout_q, sum_q},
          {27'd0, m_valid, m_zero_q, m_ovf_q, m_cout_q, m_sum_q});
  endtask

  // Drive one set of inputs, check the comb path, clock once, then check the registers.
  task automatic cycle(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic tv, input string tag);
    int total;
    a = ta; b = tb_; cin = tc; in_valid = tv;
    #1 check_comb({tag, "_comb"});
    @(posedge clk);
    total = int'(ta) + int'(tb_) + int'(tc);
    if (!rst_n) begin
      m_sum_q = '0; m_cout_q = 0; m_ovf_q = 0; m_zero_q = 0; m_valid = 0;
    end else begin
      m_valid = tv;
      if (tv) begin
        m_sum_q  = W'(total % MOD);
        m_cout_q = (total >= MOD);
        m_ovf_q  = ref_ovf(int'(ta), int'(tb_), int'(tc));
        m_zero_q = ((total % MOD) == 0);
      end
    end
    #1 check_regs({tag, "_regs"});
  endtask

  initial begin
    // Reset state with no clock edge ever seen.
    #1 check_regs("reset_state");

    // Exhaustive comb sweep, clock idle and reset held (reset must not touch this path).
    for (int ia = 0; ia < MOD; ia++)
      for (int ib = 0; ib < MOD; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          a = W'(ia); b = W'(ib); cin = ic[0];
          #5 check_comb("sweep");
          check("sweep_cla", {31'd0, cout}, {31'd0, grp_g | (grp_p & cin)});
        end

    // Clock running under reset: captures must be ignored.
    clk_en = 1'b1;
    cycle(4'h3, 4'h4, 1'b0, 1'b1, "in_reset");
    // Deassert between edges; in_valid on the very next edge is captured.
    #2 rst_n = 1'b1;
    cycle(4'h2, 4'h5, 1'b1, 1'b1, "first_capture");

    // All-ones wrap and exact 2^W wrap.
    cycle(4'hF, 4'hF, 1'b1, 1'b1, "all_ones");
    check("all_ones_sum", {28'd0, sum_q}, 32'hF);
    a = 4'hF; b = 4'h0; cin = 1'b1; in_valid = 1'b1;
    #1 check("wrap_comb", {25'd0, grp_p, grp_g, cout, sum}, {25'd0, 1'b1, 1'b0, 1'b1, 4'h0});
    cycle(4'hF, 4'h0, 1'b1, 1'b1, "wrap");
    check("wrap_zero_ovf", {30'd0, zero_q, ovf_q}, {30'd0, 1'b1, 1'b0});

    // Positive overflow then hold.
    cycle(4'h7, 4'h1, 1'b0, 1'b1, "pos_ovf");
    check("pos_ovf_regs", {25'd0, out_valid, ovf_q, cout_q, sum_q}, {25'd0, 1'b1, 1'b1, 1'b0, 4'h8});
    cycle(4'h2, 4'h3, 1'b0, 1'b0, "hold");
    check("hold_regs", {27'd0, out_valid, sum_q}, {27'd0, 1'b0, 4'h8});

    // Negative overflow with sum zero and carry set.
    cycle(4'h8, 4'h8, 1'b0, 1'b1, "neg_ovf");
    check("neg_ovf_regs", {25'd0, zero_q, ovf_q, cout_q, sum_q}, {25'd0, 1'b1, 1'b1, 1'b1, 4'h0});

    // Four back-to-back captures.
    cycle(4'h1, 4'h2, 1'b0, 1'b1, "b2b0");
    cycle(4'h3, 4'h4, 1'b1, 1'b1, "b2b1");
    cycle(4'h5, 4'h9, 1'b0, 1'b1, "b2b2");
    cycle(4'hA, 4'hC, 1'b1, 1'b1, "b2b3");

    // Asynchronous reset between edges after a capture.
    #2 rst_n = 1'b0;
    m_sum_q = '0; m_cout_q = 0; m_ovf_q = 0; m_zero_q = 0; m_valid = 0;
    #1 check_regs("async_rst");
    check_comb("async_rst_comb");
    check("async_rst_sum", {27'd0, cout, sum}, {27'd0, 1'b1, 4'h7});
    #2 rst_n = 1'b1;
    cycle(4'h0, 4'h0, 1'b0, 1'b0, "after_rst_idle");
    cycle(4'h6, 4'h6, 1'b0, 1'b1, "after_rst_cap");

    // Randomized stream.
    for (int n = 0; n < 300; n++)
      cycle(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top_module_add4.md
TOP_MODULE_ADD4 -- requirements
Module: top_module_add4

Interface
REQ-001 Parameter WIDTH, default 4, operand width; all requirements below use WIDTH=4 and SHALL scale to any WIDTH>=1.
REQ-002 clk  input  1  single clock; all registers SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  WIDTH  unsigned operand A.
REQ-005 b  input  WIDTH  unsigned operand B.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  qualifies a/b/cin for capture into the registered result.
REQ-008 sum  output  WIDTH  combinational sum, low WIDTH bits of a+b+cin.
REQ-009 cout  output  1  combinational carry-out, bit WIDTH of a+b+cin.
REQ-010 grp_p  output  1  combinational group propagate, AND of (a[i]^b[i]).
REQ-011 grp_g  output  1  combinational group generate, carry-out assuming cin=0.
REQ-012 sum_q  output  WIDTH  registered sum.
REQ-013 cout_q  output  1  registered carry-out.
REQ-014 ovf_q  output  1  registered two's-complement overflow flag.
REQ-015 zero_q  output  1  registered flag, high when sum_q is all zeros.
REQ-016 out_valid  output  1  high for the cycle(s) in which sum_q/cout_q/ovf_q/zero_q hold a new result.

Function
REQ-017 {cout,sum} SHALL equal a+b+cin exactly, for all 2^(2*WIDTH+1) input combinations, with no dependence on clk, rst_n or in_valid.
REQ-018 The combinational path SHALL be carry-lookahead: per-bit g[i]=a[i]&b[i], p[i]=a[i]^b[i], c[i+1]=g[i]|(p[i]&c[i]) expanded, c[0]=cin, sum[i]=p[i]^c[i].
REQ-019 cout SHALL equal grp_g | (grp_p & cin) for every input.
REQ-020 Combinational outputs SHALL settle within one input-change interval of 5 ns; no latches, no internal state on this path.
REQ-021 On a rising clk edge with in_valid=1: sum_q<=sum, cout_q<=cout, ovf_q<=(a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), zero_q<=(sum==0), out_valid<=1.
REQ-022 On a rising clk edge with in_valid=0: sum_q, cout_q, ovf_q, zero_q SHALL hold; out_valid<=0.
REQ-023 Latency: registered result SHALL appear exactly 1 clk cycle after the capturing edge; back-to-back in_valid SHALL give one result per cycle, no stalls.
REQ-024 Wrap-around: a=b=all-ones, cin=1 SHALL give sum=all-ones, cout=1; a+b+cin = 2^WIDTH SHALL give sum=0, cout=1, zero_q=1 after capture.
REQ-025 zero_q SHALL reflect sum only, not cout (sum=0 with cout=1 still sets zero_q).

Reset
REQ-026 While rst_n=0: sum_q=0, cout_q=0, ovf_q=0, zero_q=0, out_valid=0, asserted immediately without a clk edge.
REQ-027 Reset SHALL NOT affect sum, cout, grp_p, grp_g.
REQ-028 Deassertion of rst_n SHALL take effect at the next rising clk; an in_valid present on that edge SHALL be captured normally.
REQ-029 Reset asserted mid-stream SHALL discard any pending result; out_valid SHALL be 0 until a new capture.

Verification
REQ-030 Exhaustive sweep: a 0..15, b 0..15, cin 0..1, 5 ns per vector, clk idle -> {cout,sum}==a+b+cin for all 512 vectors.
REQ-031 a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1, grp_p=1, grp_g=0; captured -> zero_q=1, ovf_q=0.
REQ-032 a=4'h7, b=4'h1, cin=0, in_valid=1, one edge -> sum_q=4'h8, cout_q=0, ovf_q=1, out_valid=1; next edge with in_valid=0 -> out_valid=0, sum_q=4'h8 held.
REQ-033 a=4'h8, b=4'h8, cin=0 captured -> sum_q=4'h0, cout_q=1, ovf_q=1, zero_q=1.
REQ-034 rst_n low between edges after a capture -> registered outputs and out_valid 0 immediately; sum/cout unchanged.
REQ-035 in_valid high 4 consecutive cycles with distinct operands -> 4 consecutive correct results, out_valid high each cycle.
